// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath types: mul/div op encodings, FSM states, default width
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO result registers
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst     in   1      asynchronous active-low reset
//   start   in   1      launch op, sampled only in IDLE
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val  in   WIDTH  multiplicand / dividend
//   rt_val  in   WIDTH  multiplier / divisor
//   hi_we   in   1      MTHI write strobe (IDLE only)
//   lo_we   in   1      MTLO write strobe (IDLE only)
//   wdata   in   WIDTH  MTHI/MTLO data
//   busy    out  1      high while the FSM is not in IDLE
//   done    out  1      one-cycle pulse after HI/LO are updated by an op
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    // Two's-complement magnitude, applied only when en is set (signed ops).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    md_state_e state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    // Multiply: {partial product high, multiplier shifting out the bottom}.
    // Divide:   {partial remainder, dividend shifting in / quotient bits shifting out}.
    logic [2*WIDTH-1:0] acc;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]   oper;
    logic [WIDTH-1:0]   rs_raw;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               div_zero;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_rs;
    logic [WIDTH-1:0]   abs_rt;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign op_signed = ~op[0];
    assign abs_rs    = abs_val(rs_val, op_signed);
    assign abs_rt    = abs_val(rt_val, op_signed);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST_STEP) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One shift-add multiply step. The extra sum bit is the carry that
    // becomes the new accumulator MSB after the right shift.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, oper};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                          : {1'b0, acc[2*WIDTH-1:1]};
    end

    // One restoring divide step. The shifted remainder needs WIDTH+1 bits;
    // when it is >= divisor the true difference fits in WIDTH bits.
    always_comb begin
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = (rem_sh >= {1'b0, oper});
        div_diff = rem_sh[WIDTH-1:0] - oper;
        div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                          : {acc[2*WIDTH-2:0], 1'b0};
    end

    // Sign fix-up of the magnitude result.
    always_comb begin
        prod_fix = neg_main ? (~acc + (2*WIDTH)'(1)) : acc;
        quo_fix  = neg_main ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
        rem_fix  = neg_rem  ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                // Signed ops would otherwise negate the all-ones quotient.
                fix_lo = '1;
                fix_hi = rs_raw;
            end else begin
                fix_lo = quo_fix;
                fix_hi = rem_fix;
            end
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            acc      <= '0;
            oper     <= '0;
            rs_raw   <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        cnt      <= '0;
                        is_div   <= op[1];
                        rs_raw   <= rs_val;
                        div_zero <= (rt_val == '0);
                        neg_main <= op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_rem  <= op_signed & rs_val[WIDTH-1];
                        if (op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, abs_rs};
                            oper <= abs_rt;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, abs_rt};
                            oper <= abs_rs;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= is_div ? div_next : mul_next;
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts negedges until done, with a bound; busy samples counted on the way.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int bcnt;

        vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_neg3x7", OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_by0",    OP_DIVU,  32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu_100_7",  OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{"mult_m2xm3",  OP_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
        vecs[7]  = '{"div_7_m2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{"div_m5_by0",  OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{"multu_2p16",  OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[10] = '{"div_min_1",   OP_DIV,   32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000};

        rst    = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi",   hi, 32'd0);
        chk("reset_lo",   lo, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven ops: latency, busy length, results.
        foreach (vecs[i]) begin
            launch(vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_done(cyc, bcnt);
            chk({vecs[i].name, "_latency"}, cyc,  32'd33);
            chk({vecs[i].name, "_busy"},    bcnt, 32'd33);
            chk({vecs[i].name, "_nobusy"},  {31'd0, busy}, 32'd0);
            chk({vecs[i].name, "_hi"},      hi, vecs[i].exp_hi);
            chk({vecs[i].name, "_lo"},      lo, vecs[i].exp_lo);
            @(negedge clk);
            chk({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
        end

        // Start, new operands and an MTLO while busy are all ignored.
        launch(OP_MULTU, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        start  = 1'b1;
        op     = OP_DIV;
        rs_val = 32'd99;
        rt_val = 32'd3;
        lo_we  = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        start  = 1'b0;
        lo_we  = 1'b0;
        chk("busy_lo_we_ignored", lo, 32'h80000000);
        wait_done(cyc, bcnt);
        chk("midcalc_latency", cyc, 32'd22);
        chk("midcalc_hi", hi, 32'd0);
        chk("midcalc_lo", lo, 32'd15);

        // Start in the done cycle is accepted.
        launch(OP_DIVU, 32'd100, 32'd7);
        chk("done_cycle_start_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc, bcnt);
        chk("done_cycle_latency", cyc, 32'd33);
        chk("done_cycle_hi", hi, 32'd2);
        chk("done_cycle_lo", lo, 32'd14);

        // MTHI in IDLE.
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo_kept", lo, 32'd14);

        // Asynchronous reset mid-CALC, then a clean op.
        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_hi",   hi, 32'd0);
        chk("async_rst_lo",   lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        launch(OP_MULTU, 32'd3, 32'd5);
        wait_done(cyc, bcnt);
        chk("post_rst_latency", cyc, 32'd33);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
